// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU signals between two requesters and the arbiter.
// The arbiter takes the slave view; the requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
    parameter int DATA_BITS = 8
);
    logic                 r0_valid;
    logic                 r0_ready;
    logic [DATA_BITS-1:0] r0_a;
    logic [DATA_BITS-1:0] r0_b;
    logic [DATA_BITS-1:0] r0_op;
    logic                 r0_resp_valid;
    logic                 r0_resp_ready;

    logic                 r1_valid;
    logic                 r1_ready;
    logic [DATA_BITS-1:0] r1_a;
    logic [DATA_BITS-1:0] r1_b;
    logic [DATA_BITS-1:0] r1_op;
    logic                 r1_resp_valid;
    logic                 r1_resp_ready;

    logic [DATA_BITS-1:0] resp_data;
    logic [DATA_BITS-1:0] alu_a;
    logic [DATA_BITS-1:0] alu_b;
    logic [DATA_BITS-1:0] alu_op;
    logic [DATA_BITS-1:0] alu_result;
    logic                 busy;
    logic [7:0]           op_count;

    modport master (
        output r0_valid, r0_a, r0_b, r0_op, r0_resp_ready,
        output r1_valid, r1_a, r1_b, r1_op, r1_resp_ready,
        output alu_result,
        input  r0_ready, r0_resp_valid, r1_ready, r1_resp_valid,
        input  resp_data, alu_a, alu_b, alu_op, busy, op_count
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_op, r0_resp_ready,
        input  r1_valid, r1_a, r1_b, r1_op, r1_resp_ready,
        input  alu_result,
        output r0_ready, r0_resp_valid, r1_ready, r1_resp_valid,
        output resp_data, alu_a, alu_b, alu_op, busy, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; result 2 cycles after accept.
// Holds the response until the granted requester's resp_ready; no new request is accepted meanwhile.
module alu_arbiter #(
    parameter int DATA_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] a;
        logic [DATA_BITS-1:0] b;
        logic [DATA_BITS-1:0] op;
    } opnd_t;

    state_t               r_state;
    state_t               w_state_nxt;
    opnd_t                r_opnd;
    opnd_t                w_opnd_sel;
    logic [DATA_BITS-1:0] r_result;
    logic                 r_grant;
    logic                 r_last_grant;
    logic [7:0]           r_op_count;

    logic                 w_grant;
    logic                 w_r0_ready;
    logic                 w_r1_ready;
    logic                 w_r0_resp_valid;
    logic                 w_r1_resp_valid;
    logic                 w_accept;
    logic                 w_resp_done;
    logic                 w_active;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (bus.r0_valid && bus.r1_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.r1_valid) begin
            w_grant = 1'b1;
        end
    end

    always_comb begin
        w_opnd_sel = w_grant ? opnd_t'{bus.r1_a, bus.r1_b, bus.r1_op}
                             : opnd_t'{bus.r0_a, bus.r0_b, bus.r0_op};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_r0_ready      = 1'b0;
        w_r1_ready      = 1'b0;
        w_r0_resp_valid = 1'b0;
        w_r1_resp_valid = 1'b0;
        w_accept        = 1'b0;
        w_resp_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    w_r0_ready = bus.r0_valid && !w_grant;
                    w_r1_ready = bus.r1_valid &&  w_grant;
                end
                w_accept = w_r0_ready || w_r1_ready;
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!rst) begin
                    w_r0_resp_valid = !r_grant;
                    w_r1_resp_valid =  r_grant;
                end
                // Only the granted requester's resp_ready can retire the response.
                w_resp_done = (w_r0_resp_valid && bus.r0_resp_ready) ||
                              (w_r1_resp_valid && bus.r1_resp_ready);
                if (w_resp_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_opnd       <= '0;
            r_result     <= '0;
            r_op_count   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_grant <= w_grant;
                r_opnd  <= w_opnd_sel;
            end
            if (r_state == ST_EXEC) begin
                r_result <= bus.alu_result;
            end
            if (w_resp_done) begin
                r_last_grant <= r_grant;
                r_op_count   <= r_op_count + 8'd1;
            end
        end
    end

    assign w_active = (r_state != ST_IDLE) && !rst;

    assign bus.r0_ready      = w_r0_ready;
    assign bus.r1_ready      = w_r1_ready;
    assign bus.r0_resp_valid = w_r0_resp_valid;
    assign bus.r1_resp_valid = w_r1_resp_valid;
    assign bus.resp_data     = (w_r0_resp_valid || w_r1_resp_valid) ? r_result : '0;
    assign bus.alu_a         = w_active ? r_opnd.a  : '0;
    assign bus.alu_b         = w_active ? r_opnd.b  : '0;
    assign bus.alu_op        = w_active ? r_opnd.op : '0;
    assign bus.busy          = w_active;
    assign bus.op_count      = r_op_count;

    a_single_ready: assert property (@(posedge clk) !(bus.r0_ready && bus.r1_ready));
    a_ready_vs_resp: assert property (@(posedge clk)
        !((bus.r0_ready || bus.r1_ready) && (bus.r0_resp_valid || bus.r1_resp_valid)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, with a queue-based
// scoreboard fed at issue time and drained by an independent response monitor.
module tb_alu_arbiter;

    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_BITS(DB)) ifc ();

    alu_arbiter #(.DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Bench ALU: plain 8-bit addition.
    assign ifc.alu_result = ifc.alu_a + ifc.alu_b;

    logic       rr_rand;
    logic       rr0;
    logic       rr1;
    logic [1:0] rnd;
    always @(posedge clk) rnd <= 2'($urandom);
    assign ifc.r0_resp_ready = rr_rand ? rnd[0] : rr0;
    assign ifc.r1_resp_ready = rr_rand ? rnd[1] : rr1;

    typedef struct {
        bit         id;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    bit   m_last;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Response monitor: independent of the stimulus thread.
    logic [7:0] exp_cnt;
    bit         prev_pend;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        bit   hs;
        exp_t e;
        if (rst) begin
            exp_cnt   = 8'd0;
            prev_pend = 1'b0;
        end else begin
            check("op_count", ifc.op_count, exp_cnt);
            if (ifc.r0_resp_valid || ifc.r1_resp_valid) begin
                check("resp_overlap", ifc.r0_resp_valid & ifc.r1_resp_valid, 0);
                check("ready_in_resp", ifc.r0_ready | ifc.r1_ready, 0);
                if (prev_pend) check("resp_stable", ifc.resp_data, prev_data);
            end
            hs = (ifc.r0_resp_valid && ifc.r0_resp_ready) || (ifc.r1_resp_valid && ifc.r1_resp_ready);
            if (hs) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", ifc.resp_data);
                end else begin
                    e = q.pop_front();
                    check("resp_id", ifc.r1_resp_valid, e.id);
                    check("resp_data", ifc.resp_data, e.data);
                end
                exp_cnt = exp_cnt + 8'd1;
            end
            prev_pend = (ifc.r0_resp_valid || ifc.r1_resp_valid) && !hs;
            prev_data = ifc.resp_data;
        end
    end

    // Present a request; the model predicts the winner and its sum, then waits for the grant.
    task automatic issue(input bit v0, input bit v1,
                         input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] o0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] o1,
                         output int waited);
        bit         w;
        bit         got;
        logic [7:0] s;
        @(posedge clk);
        #1;
        ifc.r0_valid = v0; ifc.r0_a = a0; ifc.r0_b = b0; ifc.r0_op = o0;
        ifc.r1_valid = v1; ifc.r1_a = a1; ifc.r1_b = b1; ifc.r1_op = o1;
        w = (v0 && v1) ? ~m_last : v1;
        s = w ? a1 + b1 : a0 + b0;
        q.push_back('{id: w, data: s});
        m_last = w;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (ifc.r0_ready || ifc.r1_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            fail_now("grant_wait");
        end else begin
            check("grant_r0", ifc.r0_ready, !w);
            check("grant_r1", ifc.r1_ready, w);
        end
        @(posedge clk);
        #1;
        ifc.r0_valid = 1'b0;
        ifc.r1_valid = 1'b0;
        ifc.r0_a = 8'($urandom); ifc.r0_b = 8'($urandom); ifc.r0_op = 8'($urandom);
        ifc.r1_a = 8'($urandom); ifc.r1_b = 8'($urandom); ifc.r1_op = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
            if (q.size() == 0 && !ifc.busy) done = 1'b1;
        end
        if (!done) fail_now("drain");
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifc.r0_valid = 1'b0;
        ifc.r1_valid = 1'b0;
        q.delete();
        m_last = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   waited;
        int   n;
        bit   got;
        logic [1:0] v;
        rst = 1'b1;
        rr_rand = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        m_last = 1'b1;
        ifc.r0_valid = 1'b1; ifc.r0_a = 8'h0; ifc.r0_b = 8'h0; ifc.r0_op = 8'h0;
        ifc.r1_valid = 1'b0; ifc.r1_a = 8'h0; ifc.r1_b = 8'h0; ifc.r1_op = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_ready_held", {ifc.r0_ready, ifc.r1_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.r0_valid = 1'b0;
        @(negedge clk);
        check("rst_flags", {ifc.r0_ready, ifc.r1_ready, ifc.r0_resp_valid, ifc.r1_resp_valid, ifc.busy}, 0);
        check("rst_data", {ifc.resp_data, ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.op_count}, 0);

        // Single request with operand change after accept.
        issue(1, 0, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, waited);
        check("single_ready_now", waited, 0);
        ifc.r0_a = 8'hFF;
        @(negedge clk);
        check("exec_busy", ifc.busy, 1);
        check("exec_no_resp", ifc.r0_resp_valid, 0);
        check("exec_alu_a", ifc.alu_a, 8'h01);
        check("exec_alu_op", ifc.alu_op, 8'h04);
        @(negedge clk);
        check("resp_latency", ifc.r0_resp_valid, 1);
        check("resp_data_03", ifc.resp_data, 8'h03);
        @(negedge clk);
        check("single_count", ifc.op_count, 8'd1);
        check("single_idle", ifc.busy, 0);
        check("idle_alu_a", ifc.alu_a, 8'h00);

        // Contention straight after reset: r0 first, then r1.
        reset_dut();
        issue(1, 1, 8'h10, 8'h01, 8'h00, 8'h20, 8'h02, 8'h00, waited);
        issue(0, 1, 8'h00, 8'h00, 8'h00, 8'h20, 8'h02, 8'h00, waited);
        drain();

        // Sustained contention: alternation checked by the grant comparisons in issue.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 8'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom), 8'($urandom), 8'($urandom), waited);
        end
        drain();
        check("sustained_count", ifc.op_count, 8'd4);

        // Backpressure on r1 while r0 waits.
        rr1 = 1'b0;
        issue(0, 1, 8'h00, 8'h00, 8'h00, 8'h20, 8'h02, 8'h00, waited);
        ifc.r0_valid = 1'b1; ifc.r0_a = 8'h05; ifc.r0_b = 8'h06; ifc.r0_op = 8'h00;
        got = 1'b0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (ifc.r1_resp_valid) got = 1'b1;
        end
        if (!got) fail_now("bp_resp_wait");
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_valid", ifc.r1_resp_valid, 1);
            check("bp_data", ifc.resp_data, 8'h22);
            check("bp_r0_ready", ifc.r0_ready, 0);
        end
        @(posedge clk);
        #1;
        rr1 = 1'b1;
        q.push_back('{id: 1'b0, data: 8'h0B});
        m_last = 1'b0;
        @(negedge clk);
        check("bp_last_valid", ifc.r1_resp_valid, 1);
        @(negedge clk);
        check("bp_released", ifc.r1_resp_valid, 0);
        check("bp_r0_granted", ifc.r0_ready, 1);
        @(posedge clk);
        #1;
        ifc.r0_valid = 1'b0;
        drain();

        // Reset while a response is pending.
        reset_dut();
        rr0 = 1'b0;
        issue(1, 0, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, waited);
        got = 1'b0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (ifc.r0_resp_valid) got = 1'b1;
        end
        if (!got) fail_now("abort_resp_wait");
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        m_last = 1'b1;
        @(negedge clk);
        check("abort_during_flags", {ifc.r0_resp_valid, ifc.r1_resp_valid, ifc.busy}, 0);
        check("abort_during_data", {ifc.resp_data, ifc.alu_a, ifc.alu_b, ifc.alu_op}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rr0 = 1'b1;
        @(negedge clk);
        check("abort_after_flags", {ifc.r0_ready, ifc.r1_ready, ifc.r0_resp_valid, ifc.r1_resp_valid, ifc.busy}, 0);
        check("abort_after_data", {ifc.resp_data, ifc.alu_a, ifc.alu_b, ifc.alu_op}, 0);
        check("abort_count", ifc.op_count, 8'd0);

        // Random traffic with random response backpressure; 256 completions wrap the counter.
        rr_rand = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 2'($urandom_range(1, 3));
            issue(v[0], v[1], 8'($urandom), 8'($urandom), 8'($urandom),
                              8'($urandom), 8'($urandom), 8'($urandom), waited);
        end
        drain();
        rr_rand = 1'b0;
        check("op_count_wrap", ifc.op_count, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_BITS, default 8, width of operands, op code and result.
REQ-002 Ports, listed as name  direction  width  meaning:
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 r0_valid, r1_valid  in  1 each  requester N has an operation pending.
REQ-006 r0_ready, r1_ready  out  1 each  arbiter accepts requester N's operation this cycle.
REQ-007 r0_a, r0_b, r0_op, r1_a, r1_b, r1_op  in  DATA_BITS each  requester operands and op code.
REQ-008 r0_resp_valid, r1_resp_valid  out  1 each  result available for requester N.
REQ-009 r0_resp_ready, r1_resp_ready  in  1 each  requester N consumes the result.
REQ-010 resp_data  out  DATA_BITS  result, shared by both requesters; meaningful only with a resp_valid.
REQ-011 alu_a, alu_b, alu_op  out  DATA_BITS each  drive the shared combinational ALU (data_A, data_B, op_code).
REQ-012 alu_result  in  DATA_BITS  ALU result.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 op_count  out  8  completed operations, wrapping modulo 256.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; exactly one is active at any time.
REQ-016 Grant is round-robin. With one valid, that requester wins. With both valid, the requester not in last_grant wins.
REQ-017 IDLE: rN_ready = rN_valid AND grant==N, combinational; at most one ready is high. On handshake (valid&ready): latch a/b/op and grant, then go to EXEC next cycle.
REQ-018 rN_ready SHALL be 0 in EXEC and RESP.
REQ-019 alu_a/alu_b/alu_op SHALL drive the latched operands in EXEC and RESP, and all zero in IDLE.
REQ-020 EXEC lasts exactly one cycle. At its end, capture alu_result into the result register and go to RESP.
REQ-021 RESP: assert resp_valid of the granted requester only, and drive resp_data from the result register.
REQ-022 RESP holds resp_data stable until the matching resp_ready is sampled high. Then:
  - go to IDLE;
  - last_grant <= grant;
  - op_count increments.
REQ-023 resp_ready of the non-granted requester is ignored.
REQ-024 Latency is handshake -> resp_valid = 2 cycles. Minimum issue interval is 3 cycles per operation.
REQ-025 Inputs rN_a/b/op changing after handshake SHALL NOT affect the in-flight result.
REQ-026 A requester dropping valid in IDLE before handshake is allowed. No grant is recorded and last_grant is unchanged.
REQ-027 resp_valid and ready SHALL NOT both be high in the same cycle. A new request is never accepted while a response is pending.
REQ-028 op_count wraps 255 -> 0 with no flag.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL set:
  - state = IDLE;
  - last_grant = 1, so r0 wins the first contention;
  - result register = 0;
  - op_count = 0.
REQ-030 Output values during and after reset:
  - all rN_ready, rN_resp_valid and busy = 0;
  - resp_data, alu_a, alu_b, alu_op = 0.
REQ-031 Reset mid-operation (EXEC or RESP) aborts the operation. No response is issued and op_count does not increment.

Verification (bench ALU model: alu_result = alu_a + alu_b mod 256)
REQ-032 Single request: r0 a=01 b=02 op=04, resp_ready held 1.
  - r0_ready high in the same cycle;
  - r0_resp_valid high 2 cycles after handshake with resp_data=03;
  - op_count=1 and busy=0 one cycle later.
REQ-033 Contention after reset: r0 and r1 valid together (r0 a=10 b=01, r1 a=20 b=02).
  - r0 served first with resp_data=11;
  - r1 served next with resp_data=22;
  - r1_resp_valid never overlaps r0_resp_valid.
REQ-034 Sustained contention, both valid for 4 operations: grant order 0,1,0,1 and op_count=4.
REQ-035 Backpressure: r1_resp_ready held 0 for 5 cycles in RESP.
  - resp_valid and resp_data=22 stay stable;
  - r0_ready stays 0 throughout;
  - completes on the cycle ready rises.
REQ-036 Operand change after handshake: r0_a changes 01 -> FF after handshake; resp_data is still 03.
REQ-037 Reset in RESP: assert rst one cycle while r0_resp_valid=1.
  - next cycle: all outputs 0, state IDLE, op_count unchanged;
  - wrap check: 256 completed operations return op_count to 00.
